// File: rtl/rr_stream_mux.sv
// Registered N-channel stream multiplexer with fixed-select or round-robin
// arbitration, a source-channel tag and a wrapping 16-bit transfer counter.
module rr_stream_mux #(
  parameter  int WIDTH    = 4,
  parameter  int CHANNELS = 2,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               xfer_count
);

  localparam int unsigned NCH = CHANNELS;

  logic             en_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic             valid_q, valid_d;
  logic [15:0]      count_q, count_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic                load;
  logic                accept;
  logic                found;
  logic                push;
  int unsigned         win_i;
  int unsigned         sel_u;
  int unsigned         ptr_u;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    cand;
  logic [SEL_W-1:0]    nxt_ptr;
  logic [WIDTH-1:0]    win_data;

  assign load   = ~valid_q | out_ready;
  // en_q keeps every in_ready low until the first edge after reset release.
  assign accept = load & en_q;

  always_comb begin
    found    = 1'b0;
    win_i    = 0;
    sel_u    = 32'(sel);
    ptr_u    = 32'(ptr_q);
    grant    = '0;
    cand     = '0;
    nxt_ptr  = ptr_q;
    win_data = '0;

    if (!mode) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (i == sel_u && in_valid[i]) begin
          found = 1'b1;
          win_i = i;
        end
      end
    end else begin
      // Two passes: channels at or above ptr first, then wrap to the lowest.
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!found && in_valid[i] && i >= ptr_u) begin
          found = 1'b1;
          win_i = i;
        end
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        if (!found && in_valid[i]) begin
          found = 1'b1;
          win_i = i;
        end
      end
    end

    for (int unsigned i = 0; i < NCH; i++) begin
      if (found && i == win_i) begin
        grant[i] = 1'b1;
        cand     = SEL_W'(i);
        win_data = in_data[i*WIDTH +: WIDTH];
        nxt_ptr  = (i == NCH - 1) ? '0 : SEL_W'(i + 1);
      end
    end
  end

  assign in_ready = grant & {CHANNELS{accept}};
  assign push     = found & accept;

  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    if (push) begin
      data_d  = win_data;
      chan_d  = cand;
      valid_d = 1'b1;
      count_d = count_q + 16'd1;
      if (mode) ptr_d = nxt_ptr;
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q    <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
      ptr_q   <= '0;
    end else begin
      en_q    <= 1'b1;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data   = data_q;
  assign out_chan   = chan_q;
  assign out_valid  = valid_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: three instances (2, 4 and 3 channels)
// driven by directed vectors; monitors pop expected words on output handshakes.
module tb_rr_stream_mux;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  // A: WIDTH=4, CHANNELS=2
  logic [7:0]  a_data;
  logic [1:0]  a_valid, a_ready;
  logic        a_mode, a_sel;
  logic [3:0]  a_odata;
  logic        a_ochan, a_ovalid, a_oready;
  logic [15:0] a_cnt;
  // B: WIDTH=4, CHANNELS=4
  logic [15:0] b_data;
  logic [3:0]  b_valid, b_ready;
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [3:0]  b_odata;
  logic [1:0]  b_ochan;
  logic        b_ovalid, b_oready;
  logic [15:0] b_cnt;
  // C: WIDTH=4, CHANNELS=3
  logic [11:0] c_data;
  logic [2:0]  c_valid, c_ready;
  logic        c_mode;
  logic [1:0]  c_sel;
  logic [3:0]  c_odata;
  logic [1:0]  c_ochan;
  logic        c_ovalid, c_oready;
  logic [15:0] c_cnt;

  rr_stream_mux #(.WIDTH(4), .CHANNELS(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .mode(a_mode), .sel(a_sel), .out_data(a_odata),
    .out_chan(a_ochan), .out_valid(a_ovalid), .out_ready(a_oready),
    .xfer_count(a_cnt));

  rr_stream_mux #(.WIDTH(4), .CHANNELS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .mode(b_mode), .sel(b_sel), .out_data(b_odata),
    .out_chan(b_ochan), .out_valid(b_ovalid), .out_ready(b_oready),
    .xfer_count(b_cnt));

  rr_stream_mux #(.WIDTH(4), .CHANNELS(3)) u_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_valid(c_valid),
    .in_ready(c_ready), .mode(c_mode), .sel(c_sel), .out_data(c_odata),
    .out_chan(c_ochan), .out_valid(c_ovalid), .out_ready(c_oready),
    .xfer_count(c_cnt));

  bit [7:0] a_q[$];
  bit [7:0] b_q[$];
  bit [7:0] c_q[$];
  bit       a_mon_en = 1'b1;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: one pop per accepted output word.
  always @(negedge clk) begin
    bit [7:0] e;
    if (rst_n && a_mon_en && a_ovalid && a_oready) begin
      if (a_q.size() == 0) begin
        total++;
        $display("FAIL a_unexpected_out: got data 0x%0h with empty scoreboard", a_odata);
      end else begin
        e = a_q.pop_front();
        chk("a_out_data", a_odata, e[3:0]);
        chk("a_out_chan", a_ochan, e[7:4]);
      end
    end
  end

  always @(negedge clk) begin
    bit [7:0] e;
    if (rst_n && b_ovalid && b_oready) begin
      if (b_q.size() == 0) begin
        total++;
        $display("FAIL b_unexpected_out: got data 0x%0h with empty scoreboard", b_odata);
      end else begin
        e = b_q.pop_front();
        chk("b_out_data", b_odata, e[3:0]);
        chk("b_out_chan", b_ochan, e[7:4]);
      end
    end
  end

  always @(negedge clk) begin
    bit [7:0] e;
    if (rst_n && c_ovalid && c_oready) begin
      if (c_q.size() == 0) begin
        total++;
        $display("FAIL c_unexpected_out: got data 0x%0h with empty scoreboard", c_odata);
      end else begin
        e = c_q.pop_front();
        chk("c_out_data", c_odata, e[3:0]);
        chk("c_out_chan", c_ochan, e[7:4]);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0] valid;
    logic       mode;
    logic [1:0] sel;
    int unsigned chan;
  } rr_vec_t;

  rr_vec_t rr_tab[12];
  logic [3:0] b_word[4];

  initial begin
    bit [7:0] vv;
    bit [3:0] w;

    rr_tab[0]  = '{4'hF, 1'b1, 2'd0, 0};
    rr_tab[1]  = '{4'hF, 1'b1, 2'd0, 1};
    rr_tab[2]  = '{4'hF, 1'b1, 2'd0, 2};
    rr_tab[3]  = '{4'hF, 1'b1, 2'd0, 3};
    rr_tab[4]  = '{4'hF, 1'b1, 2'd0, 0};
    rr_tab[5]  = '{4'hF, 1'b1, 2'd0, 1};
    rr_tab[6]  = '{4'hA, 1'b1, 2'd0, 3};
    rr_tab[7]  = '{4'hA, 1'b1, 2'd0, 1};
    rr_tab[8]  = '{4'hA, 1'b1, 2'd0, 3};
    rr_tab[9]  = '{4'hA, 1'b1, 2'd0, 1};
    rr_tab[10] = '{4'hF, 1'b0, 2'd0, 0};
    rr_tab[11] = '{4'hF, 1'b1, 2'd0, 2};
    b_word[0] = 4'h9; b_word[1] = 4'h6; b_word[2] = 4'hC; b_word[3] = 4'h3;

    rst_n = 1'b0;
    a_data = 8'h5A; a_valid = '1; a_mode = 1'b0; a_sel = 1'b0; a_oready = 1'b1;
    b_data = 16'h1234; b_valid = '1; b_mode = 1'b1; b_sel = '0; b_oready = 1'b1;
    c_data = 12'h123; c_valid = '1; c_mode = 1'b0; c_sel = '0; c_oready = 1'b1;

    // Reset state
    #2;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_a_valid", a_ovalid, 0);
    chk("rst_a_data", a_odata, 0);
    chk("rst_a_chan", a_ochan, 0);
    chk("rst_a_count", a_cnt, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_c_ready", c_ready, 0);
    #10 rst_n = 1'b1;
    #1;
    chk("rel_a_ready_before_edge", a_ready, 0);
    chk("rel_b_ready_before_edge", b_ready, 0);
    a_valid = '0; b_valid = '0; c_valid = '0;
    tick();

    // A: fixed-mode exhaustive
    a_valid = 2'b11;
    for (int unsigned s = 0; s < 2; s++) begin
      for (int unsigned v = 0; v < 256; v++) begin
        vv = 8'(v);
        a_sel = s[0];
        a_data = vv;
        w = (s == 1) ? vv[7:4] : vv[3:0];
        @(negedge clk);
        chk("a_fixed_ready", a_ready, (s == 1) ? 2 : 1);
        a_q.push_back({4'(s), w});
        tick();
      end
    end
    a_valid = '0;
    tick();
    chk("a_fixed_count", a_cnt, 512);
    chk("a_idle_valid", a_ovalid, 0);
    chk("a_q_empty1", a_q.size(), 0);

    // A: backpressure
    a_sel = 1'b0; a_valid = 2'b01; a_data = 8'h05; a_oready = 1'b0;
    @(negedge clk);
    chk("bp_first_ready", a_ready, 1);
    a_q.push_back({4'd0, 4'h5});
    tick();
    a_data = 8'h0A;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready_low", a_ready, 0);
      chk("bp_data_hold", a_odata, 5);
      chk("bp_valid_hold", a_ovalid, 1);
      tick();
    end
    chk("bp_count_hold", a_cnt, 513);
    a_oready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", a_ready, 1);
    a_q.push_back({4'd0, 4'hA});
    tick();
    a_valid = '0;
    chk("bp_new_data", a_odata, 4'hA);
    chk("bp_count_inc", a_cnt, 514);
    tick();
    chk("a_q_empty2", a_q.size(), 0);

    // B: round-robin fairness, sparse valids, mode switch keeps ptr
    b_data = {b_word[3], b_word[2], b_word[1], b_word[0]};
    b_oready = 1'b1;
    for (int unsigned k = 0; k < 12; k++) begin
      b_valid = rr_tab[k].valid;
      b_mode  = rr_tab[k].mode;
      b_sel   = rr_tab[k].sel;
      @(negedge clk);
      chk("b_rr_ready", b_ready, 1 << rr_tab[k].chan);
      b_q.push_back({4'(rr_tab[k].chan), b_word[rr_tab[k].chan]});
      tick();
    end
    b_valid = '0;
    tick();
    tick();
    chk("b_count", b_cnt, 12);
    chk("b_q_empty", b_q.size(), 0);

    // C: out-of-range select
    c_mode = 1'b0; c_sel = 2'd1; c_valid = 3'b111; c_data = 12'hE71; c_oready = 1'b0;
    @(negedge clk);
    chk("c_load_ready", c_ready, 3'b010);
    c_q.push_back({4'd1, 4'h7});
    tick();
    c_sel = 2'd3;
    for (int unsigned k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("c_oor_ready_bp", c_ready, 0);
      chk("c_oor_valid_bp", c_ovalid, 1);
      tick();
    end
    c_oready = 1'b1;
    @(negedge clk);
    chk("c_oor_ready", c_ready, 0);
    tick();
    chk("c_oor_valid_drop", c_ovalid, 0);
    chk("c_oor_data_hold", c_odata, 7);
    chk("c_oor_chan_hold", c_ochan, 1);
    chk("c_oor_count", c_cnt, 1);
    @(negedge clk);
    chk("c_oor_ready2", c_ready, 0);
    tick();
    chk("c_oor_valid2", c_ovalid, 0);
    chk("c_q_empty", c_q.size(), 0);

    // A: reset mid-stream
    a_mode = 1'b0; a_sel = 1'b1; a_valid = 2'b11; a_oready = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      a_data = {4'(k + 3), 4'(k + 8)};
      @(negedge clk);
      a_q.push_back({4'd1, 4'(k + 3)});
      tick();
    end
    chk("pre_rst_data", a_odata, 5);
    chk("pre_rst_count", a_cnt, 517);
    #2 rst_n = 1'b0;
    #1;
    a_q.delete();
    a_mon_en = 1'b0;
    chk("mid_rst_valid", a_ovalid, 0);
    chk("mid_rst_data", a_odata, 0);
    chk("mid_rst_chan", a_ochan, 0);
    chk("mid_rst_count", a_cnt, 0);
    chk("mid_rst_ready", a_ready, 0);
    chk("mid_rst_b_count", b_cnt, 0);
    @(negedge clk);
    chk("in_rst_ready", a_ready, 0);
    #2 rst_n = 1'b1;
    #1;
    chk("post_rel_ready", a_ready, 0);
    tick();
    chk("first_edge_ready", a_ready, 2'b10);
    chk("first_edge_valid", a_ovalid, 0);

    // A: counter wrap over 65537 transfers
    a_data = 8'h3C;
    repeat (65535) tick();
    chk("wrap_ffff", a_cnt, 16'hFFFF);
    tick();
    chk("wrap_0000", a_cnt, 16'h0000);
    tick();
    a_valid = '0;
    chk("wrap_0001", a_cnt, 16'h0001);
    chk("wrap_data", a_odata, 3);
    chk("wrap_chan", a_ochan, 1);
    tick();
    chk("wrap_idle_count", a_cnt, 16'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised, registered N-channel × W-bit stream multiplexer. It is the clocked successor of the combinational 4-bit 2x1 mux in the adder/subtractor datapath. Each input channel carries a valid/ready handshake. Selection is either a fixed external select or round-robin arbitration. The winning word lands in a single output register with its source channel tag, and a wrap-around transfer counter reports how many words have been accepted.

## Interface
Parameters:
- WIDTH, 4, data bits per channel (≥1)
- CHANNELS, 2, number of input channels (≥2)
- SEL_W, $clog2(CHANNELS), width of select/tag fields (derived, not overridden)

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel word valid
- in_ready  output  CHANNELS  per-channel accept, at most one bit high
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel chosen in fixed mode
- out_data  output  WIDTH  registered selected word
- out_chan  output  SEL_W  source channel of out_data
- out_valid  output  1  output register holds a word
- out_ready  input  1  downstream accepts out_data
- xfer_count  output  16  number of input words accepted, wraps

## Operation
- load = ~out_valid | out_ready. The output register can take a new word this cycle.
- Fixed mode (mode=0):
  - Candidate is channel sel if in_valid[sel]=1.
  - If sel ≥ CHANNELS, there is no candidate.
  - The round-robin pointer is unchanged.
- Round-robin mode (mode=1):
  - Candidate is the first channel with in_valid=1, searching ptr, ptr+1, … CHANNELS-1, 0, … ptr-1.
- grant is one-hot of the candidate, or zero if there is none.
- in_ready[i] = load & grant[i]. This is combinational, so a channel must not make valid depend on ready.
- Transfer on channel g occurs when in_valid[g] & in_ready[g]. On the next edge:
  - out_data ← in_data[g]
  - out_chan ← g
  - out_valid ← 1
  - xfer_count ← xfer_count+1 (mod 2^16)
  - in mode 1 only: ptr ← (g+1) mod CHANNELS
- load=1 with no grant: out_valid ← 0. out_data and out_chan hold their old values.
- load=0: output register, ptr and xfer_count hold. All in_ready are 0.
- Changing mode or sel takes effect at the next arbitration (same-cycle combinational). ptr keeps its value across mode changes.
- Non-selected channels are never acknowledged. A held in_valid stays pending until granted.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_chan=0, xfer_count=0, ptr=0. in_ready is all 0 while rst_n=0.
- Reset mid-transfer discards the held word. No in_ready is asserted until the first edge after rst_n rises.
- Latency: an input word accepted at edge k is visible on out_data with out_valid=1 after edge k.
- Throughput: one word per cycle while out_ready=1. When out_valid=1, out_ready=1 and a grant coincide, pop and push happen on the same edge with no bubble.
- Backpressure: with out_valid=1 and out_ready=0, out_data, out_chan and out_valid are stable until the accepting edge.
- Round-robin fairness: with all CHANNELS valid continuously and out_ready=1, grants cycle 0,1,…,CHANNELS-1,0 starting from ptr.
- xfer_count wraps 0xFFFF → 0x0000 with no flag.

## Test plan
- Reset check: rst_n=0 asserted mid-stream → out_valid=0, out_data=0, out_chan=0, xfer_count=0, in_ready=0 immediately, without waiting for a clock.
- Fixed mode exhaustive (WIDTH=4, CHANNELS=2): mode=0, sel∈{0,1}, all 256 (in_data[1], in_data[0]) pairs, both valid, out_ready=1 → one cycle later out_data equals the selected channel's word and out_chan=sel. The unselected channel never sees in_ready=1.
- Round-robin (CHANNELS=4): all in_valid=1, out_ready=1, mode=1 → out_chan sequence 0,1,2,3,0,1. Then only channels 1 and 3 valid → alternating 1,3.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with channel 0 valid holding 0xA → in_ready=0, output frozen at the prior word. Release out_ready → next cycle out_data=0xA, and xfer_count increments by exactly 1.
- Out-of-range select: CHANNELS=3, mode=0, sel=3, all valid → in_ready=000 and out_valid drops to 0 after the held word is consumed.
- Counter wrap: drive 65537 transfers → xfer_count reads 0x0001.
